dmem_responder: RTL and testbench

Responder end of the core's data-memory port: accepts load/store requests from the RV32I core over a valid/ready handshake, applies a programmable number of wait states, and returns read data or a write acknowledgement one response beat later. Holds the data RAM with bit-granular write masking and a memory-mapped tohost register that the testbench polls for pass/fail. It replaces the zero-latency data memory so the core's multi-cycle load/store path can be exercised.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_ram_array.sv | 28 ++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types, state encodings and defaults for the data-memory responder.
// Imported by the responder top level and its RAM array.
package dmem_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DMR_TOHOST_ADDR = 32'h0000_0064;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_WAIT = 2'd1,
        DMR_RESP = 2'd2
    } dmr_state_e;

    typedef struct packed {
        logic            write;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] mask;
    } dmr_req_t;

    function automatic logic [XLEN-1:0] dmr_merge(
        input logic [XLEN-1:0] old,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] mask
    );
        return (old & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// Data RAM: synchronous bit-masked write, asynchronous read, no reset.
// Contents are held across reset.
module dmem_ram_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter     INIT_FILE   = "",
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   idx,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] mask,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= dmr_merge(mem[idx], wdata, mask);
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request port, programmable wait
// states, one-cycle response beat, data RAM and a tohost register.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int              DEPTH_WORDS = 64,
    parameter int              LATENCY     = 0,
    parameter logic [XLEN-1:0] TOHOST_ADDR = DMR_TOHOST_ADDR,
    parameter                  INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [XLEN-1:0] req_mask,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [XLEN-1:0] tohost,
    output logic            tohost_valid
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [XLEN-3:0] DEPTH_IDX = (XLEN-2)'(DEPTH_WORDS);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 0..15");
    end

    dmr_state_e      state_q;
    dmr_state_e      state_d;
    logic [3:0]      cnt_q;
    dmr_req_t        req_q;
    logic            accept;
    logic            commit;
    logic            misaligned;
    logic            hit_tohost;
    logic            in_range;
    logic            fault;
    logic            load_th;
    logic            load_ram;
    logic            ram_we;
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] load_data;

    assign accept = (state_q == DMR_IDLE) && req_valid;
    // The access commits on the edge that enters RESP.
    assign commit = (state_q == DMR_WAIT) && (cnt_q == 4'd0);

    assign misaligned = |req_q.addr[1:0];
    assign hit_tohost = (req_q.addr == TOHOST_ADDR) && !misaligned;
    assign in_range   = req_q.addr[XLEN-1:2] < DEPTH_IDX;
    assign fault      = misaligned || (!in_range && !hit_tohost);

    assign load_th  = !fault && !req_q.write && hit_tohost;
    assign load_ram = !fault && !req_q.write && !hit_tohost;
    assign ram_we   = commit && !reset && req_q.write
                    && !fault && !hit_tohost;

    dmem_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (req_q.addr[AW+1:2]),
        .wdata (req_q.wdata),
        .mask  (req_q.mask),
        .rdata (ram_rdata)
    );

    always_comb begin
        load_data = '0;
        unique case (1'b1)
            load_th:  load_data = tohost;
            load_ram: load_data = ram_rdata;
            default:  load_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DMR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DMR_IDLE: if (accept) state_d = DMR_WAIT;
            DMR_WAIT: if (cnt_q == 4'd0) state_d = DMR_RESP;
            DMR_RESP: state_d = DMR_IDLE;
            default:  state_d = DMR_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == DMR_IDLE);
        rsp_valid = (state_q == DMR_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            req_q        <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            tohost       <= '0;
            tohost_valid <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= 4'(LATENCY);
                req_q <= '{req_write, req_addr, req_wdata, req_mask};
            end else if (state_q == DMR_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (commit) begin
                rsp_rdata <= load_data;
                rsp_err   <= fault;
            end else begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
            if (commit && req_q.write && hit_tohost) begin
                tohost       <= dmr_merge(tohost, req_q.wdata, req_q.mask);
                tohost_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 0, 3 and 4.
// Expected values are hand-computed constants.
module tb_dmem_responder;

    localparam int N = 3;

    logic        clk;
    logic        reset      [N];
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_write  [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic [31:0] req_mask   [N];
    logic        rsp_valid  [N];
    logic [31:0] rsp_rdata  [N];
    logic        rsp_err    [N];
    logic [31:0] tohost     [N];
    logic        tohost_valid [N];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (64),
            .LATENCY     (g == 0 ? 0 : (g == 1 ? 3 : 4)),
            .TOHOST_ADDR (32'h0000_0064),
            .INIT_FILE   ("")
        ) u_dut (
            .clk          (clk),
            .reset        (reset[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_write    (req_write[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .req_mask     (req_mask[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g]),
            .tohost       (tohost[g]),
            .tohost_valid (tohost_valid[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input int d, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] m,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int busy,
                          output logic seen);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_mask[d]  = m;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        rd = '0; er = 1'b0; lat = -1; busy = 0; seen = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!req_ready[d]) busy++;
            if (rsp_valid[d]) begin
                rd = rsp_rdata[d];
                er = rsp_err[d];
                lat = n - 2;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic req_chk(input string tag, input int d, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] m, input logic [31:0] exp_rd,
                           input logic exp_err);
        logic [31:0] rd;
        logic        er;
        logic        seen;
        int          lat;
        int          busy;
        do_req(d, wr, a, wd, m, rd, er, lat, busy, seen);
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        if (!wr) check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_lat"}, 32'(lat), 32'(lat_of(d)));
        check({tag, "_busy"}, 32'(busy), 32'(lat_of(d) + 2));
        @(negedge clk);
        check({tag, "_beat_end"},
              {28'd0, rsp_valid[d], req_ready[d], rsp_err[d], |rsp_rdata[d]},
              32'b0100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            reset[i] = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i] = '0;
            req_wdata[i] = '0;
            req_mask[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready[0]), 32'd1);
        check("rst_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rdata", rsp_rdata[0], 32'd0);
        check("rst_err", 32'(rsp_err[0]), 32'd0);
        check("rst_tohost", tohost[0], 32'd0);
        check("rst_thv", 32'(tohost_valid[0]), 32'd0);
        for (int i = 0; i < N; i++) reset[i] = 1'b0;

        // LATENCY=0: basic store/load
        req_chk("st10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFF_FFFF, 32'h0, 1'b0);
        req_chk("ld10", 0, 1'b0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);

        // Bit-masked partial store
        req_chk("st20", 0, 1'b1, 32'h20, 32'h11223344, 32'hFFFF_FFFF, 32'h0, 1'b0);
        req_chk("st20m", 0, 1'b1, 32'h20, 32'hAABBCCDD, 32'h0000_FF00, 32'h0, 1'b0);
        req_chk("ld20", 0, 1'b0, 32'h20, 32'h0, 32'h0, 32'h1122CC44, 1'b0);

        // Faults leave memory untouched
        req_chk("ld21", 0, 1'b0, 32'h21, 32'h0, 32'h0, 32'h0, 1'b1);
        req_chk("st12", 0, 1'b1, 32'h12, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        req_chk("ld10b", 0, 1'b0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        req_chk("st00", 0, 1'b1, 32'h0, 32'h0BADF00D, 32'hFFFF_FFFF, 32'h0, 1'b0);
        req_chk("st400", 0, 1'b1, 32'h400, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        req_chk("ld00", 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);

        // Last word in range versus first word out of range
        req_chk("stfc", 0, 1'b1, 32'hFC, 32'h600DCAFE, 32'hFFFF_FFFF, 32'h0, 1'b0);
        req_chk("ldfc", 0, 1'b0, 32'hFC, 32'h0, 32'h0, 32'h600DCAFE, 1'b0);
        req_chk("ld100", 0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 1'b1);

        // tohost register
        check("th_pre_valid", 32'(tohost_valid[0]), 32'd0);
        req_chk("st64", 0, 1'b1, 32'h64, 32'h19, 32'hFFFF_FFFF, 32'h0, 1'b0);
        check("th_val", tohost[0], 32'h19);
        check("th_valid", 32'(tohost_valid[0]), 32'd1);
        req_chk("ld64", 0, 1'b0, 32'h64, 32'h0, 32'h0, 32'h19, 1'b0);
        req_chk("st64m", 0, 1'b1, 32'h64, 32'h0000_AB77, 32'h0000_FF00, 32'h0, 1'b0);
        check("th_merge", tohost[0], 32'h0000_AB19);

        // LATENCY=3 and LATENCY=4 timing
        req_chk("l3_st", 1, 1'b1, 32'h40, 32'h12345678, 32'hFFFF_FFFF, 32'h0, 1'b0);
        req_chk("l3_ld", 1, 1'b0, 32'h40, 32'h0, 32'h0, 32'h12345678, 1'b0);
        req_chk("l4_st", 2, 1'b1, 32'h30, 32'h55AA55AA, 32'hFFFF_FFFF, 32'h0, 1'b0);
        req_chk("l4_ld", 2, 1'b0, 32'h30, 32'h0, 32'h0, 32'h55AA55AA, 1'b0);

        // Reset while a store waits: dropped, no response, no write
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h30;
        req_wdata[2] = 32'hFFFF_FFFF;
        req_mask[2]  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset[2] = 1'b1;
        #1;
        check("rw_ready", 32'(req_ready[2]), 32'd1);
        check("rw_valid", 32'(rsp_valid[2]), 32'd0);
        check("rw_rdata", rsp_rdata[2], 32'd0);
        repeat (3) @(negedge clk);
        reset[2] = 1'b0;
        begin
            int beats = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rsp_valid[2]) beats++;
            end
            check("rw_no_rsp", 32'(beats), 32'd0);
        end
        req_chk("rw_ld", 2, 1'b0, 32'h30, 32'h0, 32'h0, 32'h55AA55AA, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
